// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: once per frame it moves the paddles and ball, scores points
// and runs the IDLE/SERVE/PLAY/OVER flow that feeds the VGA position inputs.
module pong_game_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PAD_W       = 8,
    parameter int PAD_H       = 64,
    parameter int BALL_SZ     = 8,
    parameter int P1_X        = 16,
    parameter int P2_X        = 616,
    parameter int PAD_STEP    = 4,
    parameter int BALL_STEP   = 2,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clock_50MHz,
    input  logic       RESET_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    input  logic [1:0] rnd,
    output logic [9:0] x1,
    output logic [9:0] y1,
    output logic [9:0] x2,
    output logic [9:0] y2,
    output logic [9:0] xb,
    output logic [9:0] yb,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic [1:0] state,
    output logic       busy
);

    localparam logic [9:0] PAD_Y0  = 10'((SCREEN_H - PAD_H) / 2);
    localparam logic [9:0] BALL_X0 = 10'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [9:0] BALL_Y0 = 10'((SCREEN_H - BALL_SZ) / 2);
    localparam logic signed [10:0] PAD_YMAX  = 11'(SCREEN_H - PAD_H);
    localparam logic signed [10:0] BALL_YMAX = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] BALL_XMAX = 11'(SCREEN_W - BALL_SZ);
    localparam logic signed [10:0] P1_FACE   = 11'(P1_X + PAD_W);
    localparam logic signed [10:0] P2_FACE   = 11'(P2_X - BALL_SZ);
    localparam logic signed [10:0] PSTEP     = 11'(PAD_STEP);
    localparam logic signed [10:0] BSTEP     = 11'(BALL_STEP);
    localparam logic signed [10:0] BSZ       = 11'(BALL_SZ);
    localparam logic signed [10:0] PH        = 11'(PAD_H);
    localparam logic [7:0] SERVE_CNT = 8'(SERVE_DELAY);
    localparam logic [3:0] WIN       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_PLAY, ST_OVER} game_state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_PAD, PH_BALL, PH_COMMIT} phase_t;

    game_state_t state_q, state_d, stg_state_q, stg_state_d;
    phase_t      phase_q, phase_d;
    logic        start_q, start_d;
    logic [9:0]  y1_q, y1_d, y2_q, y2_d, xb_q, xb_d, yb_q, yb_d;
    logic [9:0]  py1_q, py1_d, py2_q, py2_d, stg_xb_q, stg_xb_d, stg_yb_q, stg_yb_d;
    logic [3:0]  score1_q, score1_d, score2_q, score2_d, stg_sc1_q, stg_sc1_d, stg_sc2_q, stg_sc2_d;
    logic [1:0]  winner_q, winner_d, stg_win_q, stg_win_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d, stg_dx_q, stg_dx_d, stg_dy_q, stg_dy_d;
    logic [7:0]  cnt_q, cnt_d, stg_cnt_q, stg_cnt_d;

    logic signed [10:0] xb_s, ny_raw, ny_c, nx_raw, py1_s, py2_s;
    logic        flip_y, over1, over2, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]  sc1_inc, sc2_inc;

    function automatic logic [9:0] pad_move(input logic [9:0] y, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({1'b0, y});
        if (up && !dn) t = t - PSTEP;
        else if (dn && !up) t = t + PSTEP;
        if (t < 0) t = '0;
        else if (t > PAD_YMAX) t = PAD_YMAX;
        return t[9:0];
    endfunction

    assign x1     = 10'(P1_X);
    assign x2     = 10'(P2_X);
    assign y1     = y1_q;
    assign y2     = y2_q;
    assign xb     = xb_q;
    assign yb     = yb_q;
    assign score1 = score1_q;
    assign score2 = score2_q;
    assign winner = winner_q;
    assign state  = state_q;
    assign busy   = (phase_q != PH_IDLE);

    // Candidate ball move against the paddle positions computed in the PAD phase.
    always_comb begin
        xb_s    = $signed({1'b0, xb_q});
        py1_s   = $signed({1'b0, py1_q});
        py2_s   = $signed({1'b0, py2_q});
        ny_raw  = dir_y_q ? $signed({1'b0, yb_q}) - BSTEP : $signed({1'b0, yb_q}) + BSTEP;
        ny_c    = ny_raw;
        flip_y  = 1'b0;
        if (ny_raw < 0) begin
            ny_c   = '0;
            flip_y = 1'b1;
        end else if (ny_raw > BALL_YMAX) begin
            ny_c   = BALL_YMAX;
            flip_y = 1'b1;
        end
        nx_raw  = dir_x_q ? xb_s - BSTEP : xb_s + BSTEP;
        over1   = (ny_c + BSZ > py1_s) && (ny_c < py1_s + PH);
        over2   = (ny_c + BSZ > py2_s) && (ny_c < py2_s + PH);
        hit_l   = dir_x_q && (xb_s >= P1_FACE) && (nx_raw < P1_FACE) && over1;
        miss_l  = dir_x_q && !hit_l && (nx_raw < 0);
        hit_r   = !dir_x_q && (xb_s <= P2_FACE) && (nx_raw > P2_FACE) && over2;
        miss_r  = !dir_x_q && !hit_r && (nx_raw > BALL_XMAX);
        sc1_inc = score1_q + 4'd1;
        sc2_inc = score2_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;  phase_d = phase_q;  start_d = start;
        y1_d = y1_q;  y2_d = y2_q;  xb_d = xb_q;  yb_d = yb_q;
        score1_d = score1_q;  score2_d = score2_q;  winner_d = winner_q;
        dir_x_d = dir_x_q;  dir_y_d = dir_y_q;  cnt_d = cnt_q;
        py1_d = py1_q;  py2_d = py2_q;
        stg_state_d = stg_state_q;  stg_xb_d = stg_xb_q;  stg_yb_d = stg_yb_q;
        stg_sc1_d = stg_sc1_q;  stg_sc2_d = stg_sc2_q;  stg_win_d = stg_win_q;
        stg_dx_d = stg_dx_q;  stg_dy_d = stg_dy_q;  stg_cnt_d = stg_cnt_q;

        if (start && !start_q && (state_q == ST_IDLE || state_q == ST_OVER)) begin
            state_d  = ST_SERVE;
            y1_d     = PAD_Y0;   y2_d = PAD_Y0;
            xb_d     = BALL_X0;  yb_d = BALL_Y0;
            score1_d = '0;       score2_d = '0;  winner_d = '0;
            cnt_d    = SERVE_CNT;
            dir_x_d  = rnd[0];   dir_y_d = rnd[1];
        end

        // Staged results are only copied to the outputs in COMMIT, so they change as a set.
        case (phase_q)
            PH_IDLE: begin
                if (frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY)) phase_d = PH_PAD;
            end
            PH_PAD: begin
                py1_d   = pad_move(y1_q, p1_up, p1_dn);
                py2_d   = pad_move(y2_q, p2_up, p2_dn);
                phase_d = PH_BALL;
            end
            PH_BALL: begin
                stg_state_d = state_q;  stg_xb_d = xb_q;  stg_yb_d = yb_q;
                stg_sc1_d = score1_q;  stg_sc2_d = score2_q;  stg_win_d = winner_q;
                stg_dx_d = dir_x_q;  stg_dy_d = dir_y_q;  stg_cnt_d = cnt_q;
                if (state_q == ST_SERVE) begin
                    if (cnt_q == '0) stg_state_d = ST_PLAY;
                    else stg_cnt_d = cnt_q - 8'd1;
                end else if (miss_l || miss_r) begin
                    if (miss_l) stg_sc2_d = sc2_inc;
                    else stg_sc1_d = sc1_inc;
                    if ((miss_l && sc2_inc == WIN) || (miss_r && sc1_inc == WIN)) begin
                        stg_state_d = ST_OVER;
                        stg_win_d   = miss_l ? 2'd2 : 2'd1;
                        py1_d       = y1_q;
                        py2_d       = y2_q;
                    end else begin
                        stg_state_d = ST_SERVE;
                        stg_xb_d    = BALL_X0;
                        stg_yb_d    = BALL_Y0;
                        stg_dx_d    = miss_l;
                        stg_dy_d    = rnd[1];
                        stg_cnt_d   = SERVE_CNT;
                    end
                end else begin
                    stg_yb_d = ny_c[9:0];
                    stg_dy_d = dir_y_q ^ flip_y;
                    stg_xb_d = hit_l ? P1_FACE[9:0] : (hit_r ? P2_FACE[9:0] : nx_raw[9:0]);
                    stg_dx_d = hit_l ? 1'b0 : (hit_r ? 1'b1 : dir_x_q);
                end
                phase_d = PH_COMMIT;
            end
            PH_COMMIT: begin
                y1_d = py1_q;  y2_d = py2_q;  xb_d = stg_xb_q;  yb_d = stg_yb_q;
                state_d = stg_state_q;  score1_d = stg_sc1_q;  score2_d = stg_sc2_q;
                winner_d = stg_win_q;  dir_x_d = stg_dx_q;  dir_y_d = stg_dy_q;
                cnt_d = stg_cnt_q;
                phase_d = PH_IDLE;
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clock_50MHz or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;  phase_q <= PH_IDLE;  start_q <= 1'b0;
            y1_q <= PAD_Y0;  y2_q <= PAD_Y0;  xb_q <= BALL_X0;  yb_q <= BALL_Y0;
            score1_q <= '0;  score2_q <= '0;  winner_q <= '0;
            dir_x_q <= 1'b0;  dir_y_q <= 1'b0;  cnt_q <= '0;
            py1_q <= '0;  py2_q <= '0;
            stg_state_q <= ST_IDLE;  stg_xb_q <= '0;  stg_yb_q <= '0;
            stg_sc1_q <= '0;  stg_sc2_q <= '0;  stg_win_q <= '0;
            stg_dx_q <= 1'b0;  stg_dy_q <= 1'b0;  stg_cnt_q <= '0;
        end else begin
            state_q <= state_d;  phase_q <= phase_d;  start_q <= start_d;
            y1_q <= y1_d;  y2_q <= y2_d;  xb_q <= xb_d;  yb_q <= yb_d;
            score1_q <= score1_d;  score2_q <= score2_d;  winner_q <= winner_d;
            dir_x_q <= dir_x_d;  dir_y_q <= dir_y_d;  cnt_q <= cnt_d;
            py1_q <= py1_d;  py2_q <= py2_d;
            stg_state_q <= stg_state_d;  stg_xb_q <= stg_xb_d;  stg_yb_q <= stg_yb_d;
            stg_sc1_q <= stg_sc1_d;  stg_sc2_q <= stg_sc2_d;  stg_win_q <= stg_win_d;
            stg_dx_q <= stg_dx_d;  stg_dy_q <= stg_dy_d;  stg_cnt_q <= stg_cnt_d;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a frame-level reference model pushes the
// expected outputs for every tick; they are popped and compared once busy drops.
module tb_pong_game_ctrl;

    typedef logic [71:0] snap_t;
    localparam snap_t RESET_SNAP = {10'd16, 10'd208, 10'd616, 10'd208, 10'd316, 10'd236,
                                    4'd0, 4'd0, 2'd0, 2'd0};

    logic       clock_50MHz = 1'b0;
    logic       RESET_n     = 1'b0;
    logic       frame_tick  = 1'b0;
    logic       start       = 1'b0;
    logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [1:0] rnd   = 2'b00;
    logic [9:0] x1, y1, x2, y2, xb, yb;
    logic [3:0] score1, score2;
    logic [1:0] winner, state;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int m_st, m_y1, m_y2, m_xb, m_yb, m_s1, m_s2, m_win, m_dx, m_dy, m_cnt;
    snap_t exp_q[$];

    pong_game_ctrl #(.SERVE_DELAY(2)) dut (
        .clock_50MHz(clock_50MHz), .RESET_n(RESET_n), .frame_tick(frame_tick), .start(start),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .rnd(rnd),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .xb(xb), .yb(yb),
        .score1(score1), .score2(score2), .winner(winner), .state(state), .busy(busy)
    );

    always #10 clock_50MHz = ~clock_50MHz;

    function automatic snap_t dut_snap();
        return {x1, y1, x2, y2, xb, yb, score1, score2, winner, state};
    endfunction

    function automatic snap_t model_snap();
        return {10'd16, 10'(m_y1), 10'd616, 10'(m_y2), 10'(m_xb), 10'(m_yb),
                4'(m_s1), 4'(m_s2), 2'(m_win), 2'(m_st)};
    endfunction

    task automatic checkOutput(input string tag, input snap_t obs, input snap_t expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int pad_ref(input int y, input bit up, input bit dn);
        int t;
        t = y;
        if (up && !dn) t = y - 4;
        if (dn && !up) t = y + 4;
        if (t < 0) t = 0;
        if (t > 416) t = 416;
        return t;
    endfunction

    task automatic model_reset();
        m_st = 0; m_y1 = 208; m_y2 = 208; m_xb = 316; m_yb = 236;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_dx = 0; m_dy = 0; m_cnt = 0;
    endtask

    task automatic model_point(input int who, input int n1, input int n2, input bit [1:0] r);
        if (who == 1) m_s1++; else m_s2++;
        if ((who == 1 ? m_s1 : m_s2) == 9) begin
            m_st = 3; m_win = who;
        end else begin
            m_y1 = n1; m_y2 = n2; m_xb = 316; m_yb = 236;
            m_dx = (who == 2) ? 1 : 0; m_dy = r[1]; m_cnt = 2; m_st = 1;
        end
    endtask

    task automatic model_frame(input bit u1, input bit d1, input bit u2, input bit d2, input bit [1:0] r);
        int n1, n2, ny, nx, dy, dx;
        if (m_st != 1 && m_st != 2) return;
        n1 = pad_ref(m_y1, u1, d1);
        n2 = pad_ref(m_y2, u2, d2);
        if (m_st == 1) begin
            if (m_cnt == 0) m_st = 2; else m_cnt--;
            m_y1 = n1; m_y2 = n2;
            return;
        end
        dy = m_dy; ny = m_yb + (m_dy ? -2 : 2);
        if (ny < 0) begin ny = 0; dy = 1 - dy; end
        else if (ny > 472) begin ny = 472; dy = 1 - dy; end
        dx = m_dx; nx = m_xb + (m_dx ? -2 : 2);
        if (m_dx == 1) begin
            if (m_xb >= 24 && nx < 24 && ny + 8 > n1 && ny < n1 + 64) begin nx = 24; dx = 0; end
            else if (nx < 0) begin model_point(2, n1, n2, r); return; end
        end else begin
            if (m_xb <= 608 && nx > 608 && ny + 8 > n2 && ny < n2 + 64) begin nx = 608; dx = 1; end
            else if (nx > 632) begin model_point(1, n1, n2, r); return; end
        end
        m_y1 = n1; m_y2 = n2; m_xb = nx; m_yb = ny; m_dx = dx; m_dy = dy;
    endtask

    // One frame: drive controls, pulse frame_tick, count busy cycles, then compare.
    task automatic applyStimulus(input bit u1, input bit d1, input bit u2, input bit d2,
                                 input bit [1:0] r, input bit double_tick);
        int busy_cnt;
        int exp_busy;
        @(negedge clock_50MHz);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2; rnd = r; frame_tick = 1'b1;
        exp_busy = (m_st == 1 || m_st == 2) ? 3 : 0;
        model_frame(u1, d1, u2, d2, r);
        exp_q.push_back(model_snap());
        @(negedge clock_50MHz);
        frame_tick = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            frame_tick = (double_tick && i == 0);
            @(negedge clock_50MHz);
        end
        frame_tick = 1'b0;
        checkOutput("busy_cycles", snap_t'(busy_cnt), snap_t'(exp_busy));
        checkOutput("frame_outputs", dut_snap(), exp_q.pop_front());
    endtask

    task automatic pulse_start(input bit [1:0] r);
        @(negedge clock_50MHz);
        rnd = r; start = 1'b1;
        if (m_st == 0 || m_st == 3) begin
            m_st = 1; m_y1 = 208; m_y2 = 208; m_xb = 316; m_yb = 236;
            m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 2; m_dx = r[0]; m_dy = r[1];
        end
        @(negedge clock_50MHz);
        @(negedge clock_50MHz);
        start = 1'b0;
        @(negedge clock_50MHz);
        checkOutput("after_start", dut_snap(), model_snap());
    endtask

    function automatic void track(input int py, output bit up, output bit dn);
        up = (m_yb + 4) < (py + 30);
        dn = (m_yb + 4) > (py + 34);
    endfunction

    function automatic void dodge(input int py, output bit up, output bit dn);
        up = (m_yb + 4) >= 240;
        dn = !up;
        if (py < 0) up = 1'b0;
    endfunction

    initial begin
        bit u1, d1, u2, d2;
        model_reset();
        repeat (3) @(negedge clock_50MHz);
        checkOutput("reset_values", dut_snap(), RESET_SNAP);
        checkOutput("reset_busy", snap_t'(busy), '0);
        RESET_n = 1'b1;
        @(negedge clock_50MHz);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        checkOutput("idle_tick_no_change", dut_snap(), RESET_SNAP);

        pulse_start(2'b00);
        checkOutput("serve_state", snap_t'(state), snap_t'(2'd1));
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("play_after_serve", snap_t'(state), snap_t'(2'd2));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        checkOutput("first_move_xb", snap_t'(xb), snap_t'(10'd318));
        checkOutput("first_move_yb", snap_t'(yb), snap_t'(10'd238));

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
            if (i == 51) checkOutput("y1_hits_top", snap_t'(y1), '0);
        end
        checkOutput("y1_clamped", snap_t'(y1), '0);
        checkOutput("y2_both_held", snap_t'(y2), snap_t'(10'd208));

        for (int f = 0; f < 4500 && m_st != 3; f++) begin
            if (m_s2 < 3) begin
                dodge(m_y1, u1, d1); track(m_y2, u2, d2);
            end else begin
                track(m_y1, u1, d1); dodge(m_y2, u2, d2);
            end
            applyStimulus(u1, d1, u2, d2, 2'($urandom_range(0, 3)), 1'b0);
        end
        checkOutput("game_over_reached", snap_t'(state), snap_t'(2'd3));
        checkOutput("winner_p1", snap_t'(winner), snap_t'(2'd1));
        checkOutput("score1_final", snap_t'(score1), snap_t'(4'd9));

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);

        pulse_start(2'b11);
        checkOutput("restart_scores", snap_t'({score1, score2, winner}), '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0);

        @(negedge clock_50MHz);
        frame_tick = 1'b1;
        @(negedge clock_50MHz);
        frame_tick = 1'b0;
        checkOutput("busy_before_abort", snap_t'(busy), snap_t'(1'b1));
        RESET_n = 1'b0;
        #1;
        model_reset();
        checkOutput("abort_values", dut_snap(), RESET_SNAP);
        checkOutput("abort_busy", snap_t'(busy), '0);
        @(negedge clock_50MHz);
        RESET_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
